// File: rtl/pio_bus_master.sv
// Command/response front end for a simple PIO slave bus (WRITE, READ, read-modify-write); one command in flight.
// WRITE responds 2 cycles after acceptance, READ 2+READ_LATENCY, RMW 3+READ_LATENCY; response held until rsp_ready.
module pio_bus_master #(
    parameter int ADDR_W       = 3,
    parameter int DATA_W       = 32,
    parameter int READ_LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_data,
    input  logic [DATA_W-1:0] cmd_mask,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_chipselect,
    output logic              avm_write_n,
    output logic [DATA_W-1:0] avm_writedata,
    input  logic [DATA_W-1:0] avm_readdata
);

    typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_RESP} state_t;

    localparam logic [2:0] OP_WRITE = 3'd0;
    localparam logic [2:0] OP_READ  = 3'd1;
    localparam logic [2:0] OP_RMW   = 3'd2;
    localparam logic [2:0] LAT_LAST = 3'(READ_LATENCY);

    state_t              state_q, state_d;
    logic [2:0]          cnt_q, cnt_d;
    logic [2:0]          op_q, op_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [DATA_W-1:0]   mask_q, mask_d;
    logic                cmd_ready_q, cmd_ready_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
    logic                rsp_err_q, rsp_err_d;
    logic                cs_q, cs_d;
    logic                write_n_q, write_n_d;
    logic [ADDR_W-1:0]   bus_addr_q, bus_addr_d;
    logic [DATA_W-1:0]   bus_wdata_q, bus_wdata_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            op_q        <= '0;
            addr_q      <= '0;
            data_q      <= '0;
            mask_q      <= '0;
            cmd_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            cs_q        <= 1'b0;
            write_n_q   <= 1'b1;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            op_q        <= op_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            mask_q      <= mask_d;
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
            cs_q        <= cs_d;
            write_n_q   <= write_n_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
        end
    end

    // Every output is a register, so this block computes the value each output takes next cycle.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        op_d        = op_q;
        addr_d      = addr_q;
        data_d      = data_q;
        mask_d      = mask_q;
        cmd_ready_d = 1'b0;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
        cs_d        = 1'b0;
        write_n_d   = 1'b1;
        bus_addr_d  = '0;
        bus_wdata_d = '0;

        case (state_q)
            S_IDLE: begin
                cmd_ready_d = 1'b1;
                if (cmd_valid && cmd_ready_q) begin
                    cmd_ready_d = 1'b0;
                    op_d        = cmd_op;
                    addr_d      = cmd_addr;
                    data_d      = cmd_data;
                    mask_d      = cmd_mask;
                    cnt_d       = '0;
                    if (cmd_op == OP_WRITE) begin
                        state_d     = S_WRITE;
                        cs_d        = 1'b1;
                        write_n_d   = 1'b0;
                        bus_addr_d  = cmd_addr;
                        bus_wdata_d = cmd_data;
                    end else if (cmd_op == OP_READ || cmd_op == OP_RMW) begin
                        state_d    = S_READ;
                        cs_d       = 1'b1;
                        bus_addr_d = cmd_addr;
                    end else begin
                        state_d     = S_RESP;
                        rsp_valid_d = 1'b1;
                        rsp_data_d  = '0;
                        rsp_err_d   = 1'b1;
                    end
                end
            end

            S_READ: begin
                cs_d       = 1'b1;
                bus_addr_d = addr_q;
                if (cnt_q == LAT_LAST) begin
                    cnt_d = '0;
                    if (op_q == OP_RMW) begin
                        state_d     = S_WRITE;
                        write_n_d   = 1'b0;
                        bus_wdata_d = (avm_readdata & ~mask_q) | (data_q & mask_q);
                    end else begin
                        state_d     = S_RESP;
                        cs_d        = 1'b0;
                        bus_addr_d  = '0;
                        rsp_valid_d = 1'b1;
                        rsp_data_d  = avm_readdata;
                        rsp_err_d   = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end

            S_WRITE: begin
                state_d     = S_RESP;
                rsp_valid_d = 1'b1;
                rsp_data_d  = bus_wdata_q;
                rsp_err_d   = 1'b0;
            end

            S_RESP: begin
                if (rsp_ready) begin
                    state_d     = S_IDLE;
                    cmd_ready_d = 1'b1;
                    rsp_valid_d = 1'b0;
                    rsp_data_d  = '0;
                    rsp_err_d   = 1'b0;
                end
            end

            default: begin
                state_d     = S_IDLE;
                cmd_ready_d = 1'b1;
            end
        endcase
    end

    assign cmd_ready      = cmd_ready_q;
    assign rsp_valid      = rsp_valid_q;
    assign rsp_data       = rsp_data_q;
    assign rsp_err        = rsp_err_q;
    assign avm_address    = bus_addr_q;
    assign avm_chipselect = cs_q;
    assign avm_write_n    = write_n_q;
    assign avm_writedata  = bus_wdata_q;

endmodule

// File: tb/tb_pio_bus_master.sv
// Randomized bench for pio_bus_master: per-command cycle/bus expectations from a register-file model plus a bus slave.
module tb_pio_bus_master;

    localparam int AW = 3;
    localparam int DW = 32;
    localparam int RL = 1;
    localparam int NREG = 1 << AW;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [2:0]    cmd_op;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_data;
    logic [DW-1:0] cmd_mask;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_data;
    logic          rsp_err;
    logic [AW-1:0] avm_address;
    logic          avm_chipselect;
    logic          avm_write_n;
    logic [DW-1:0] avm_writedata;
    logic [DW-1:0] avm_readdata;

    pio_bus_master #(.ADDR_W(AW), .DATA_W(DW), .READ_LATENCY(RL)) dut (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_mask(cmd_mask),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .avm_address(avm_address), .avm_chipselect(avm_chipselect), .avm_write_n(avm_write_n),
        .avm_writedata(avm_writedata), .avm_readdata(avm_readdata)
    );

    always #5 clk = ~clk;

    // Bus slave: registered read data from the presented address, writes on chipselect && !write_n.
    logic [DW-1:0] slv_mem [NREG];
    always @(posedge clk) begin
        avm_readdata <= slv_mem[avm_address];
        if (avm_chipselect && !avm_write_n) slv_mem[avm_address] <= avm_writedata;
    end

    logic [DW-1:0] ref_mem [NREG];
    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;
    int prev_acc;
    int prev_len;
    bit have_prev;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic scramble_cmd();
        cmd_op   = 3'($urandom);
        cmd_addr = AW'($urandom);
        cmd_data = $urandom;
        cmd_mask = $urandom;
    endtask

    task automatic chk_idle_bus(input string tag);
        chk({tag, "_cs"}, 64'(avm_chipselect), 64'(0));
        chk({tag, "_wn"}, 64'(avm_write_n), 64'(1));
        chk({tag, "_addr"}, 64'(avm_address), 64'(0));
        chk({tag, "_wd"}, 64'(avm_writedata), 64'(0));
    endtask

    // Called just after a falling edge with the DUT idle; returns just after a falling edge, idle again.
    task automatic run_cmd(input logic [2:0] op, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, input logic [DW-1:0] m, input int stall);
        int rk;
        int wk;
        int acc;
        bit rd;
        logic [DW-1:0] exp_d;
        logic exp_err;
        logic exp_cs;
        exp_err = 1'b0;
        wk = 0;
        rd = 1'b0;
        case (op)
            3'd0: begin rk = 2;      wk = 1;      exp_d = d; end
            3'd1: begin rk = 2 + RL; rd = 1'b1;   exp_d = ref_mem[a]; end
            3'd2: begin rk = 3 + RL; wk = 2 + RL; rd = 1'b1; exp_d = (ref_mem[a] & ~m) | (d & m); end
            default: begin rk = 1;   exp_d = '0;  exp_err = 1'b1; end
        endcase
        if (op == 3'd0 || op == 3'd2) ref_mem[a] = exp_d;

        chk("cmd_ready_idle", 64'(cmd_ready), 64'(1));
        cmd_valid = 1'b1;
        cmd_op = op; cmd_addr = a; cmd_data = d; cmd_mask = m;
        @(posedge clk);
        acc = cyc;
        if (have_prev) chk("accept_interval", 64'(acc - prev_acc), 64'(prev_len));
        for (int k = 1; k <= rk; k++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            scramble_cmd();
            exp_cs = (k == wk) || (rd && k <= 1 + RL);
            chk("bus_cs", 64'(avm_chipselect), 64'(exp_cs));
            chk("bus_wn", 64'(avm_write_n), 64'(k != wk));
            chk("bus_addr", 64'(avm_address), exp_cs ? 64'(a) : 64'(0));
            chk("bus_wd", 64'(avm_writedata), (k == wk) ? 64'(exp_d) : 64'(0));
            chk("rsp_valid_timing", 64'(rsp_valid), 64'(k == rk));
            chk("cmd_ready_busy", 64'(cmd_ready), 64'(0));
        end
        chk("rsp_data", 64'(rsp_data), 64'(exp_d));
        chk("rsp_err", 64'(rsp_err), 64'(exp_err));
        if (stall == 0) rsp_ready = 1'b1;
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            chk("hold_valid", 64'(rsp_valid), 64'(1));
            chk("hold_data", 64'(rsp_data), 64'(exp_d));
            chk("hold_err", 64'(rsp_err), 64'(exp_err));
            chk("hold_cmd_ready", 64'(cmd_ready), 64'(0));
            chk_idle_bus("hold");
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("post_hs_valid", 64'(rsp_valid), 64'(0));
        chk("post_hs_ready", 64'(cmd_ready), 64'(1));
        prev_acc = acc;
        prev_len = rk + stall + 1;
        have_prev = 1'b1;
    endtask

    initial begin
        reset_n = 1'b0;
        cmd_valid = 1'b0;
        rsp_ready = 1'b0;
        cmd_op = '0; cmd_addr = '0; cmd_data = '0; cmd_mask = '0;
        have_prev = 1'b0;
        prev_acc = 0;
        prev_len = 0;
        for (int i = 0; i < NREG; i++) begin
            slv_mem[i] = $urandom;
            ref_mem[i] = slv_mem[i];
        end
        repeat (2) @(negedge clk);
        chk("rst_cmd_ready", 64'(cmd_ready), 64'(1));
        chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("rst_rsp_err", 64'(rsp_err), 64'(0));
        chk("rst_rsp_data", 64'(rsp_data), 64'(0));
        chk_idle_bus("rst");
        reset_n = 1'b1;

        // Directed scenarios, accepted on the first edge after reset release.
        run_cmd(3'd0, 3'd0, 32'h5, 32'h0, 0);
        run_cmd(3'd0, 3'd0, 32'hA, 32'h0, 0);
        run_cmd(3'd1, 3'd0, 32'h0, 32'h0, 0);
        run_cmd(3'd0, 3'd0, 32'hC, 32'h0, 0);
        run_cmd(3'd2, 3'd0, 32'h1, 32'h3, 0);
        run_cmd(3'd5, 3'd0, 32'hFFFF, 32'hFFFF, 0);
        run_cmd(3'd1, 3'd0, 32'h0, 32'h0, 10);
        chk("model_rmw_value", 64'(ref_mem[0]), 64'(32'hD));

        // Reset during the RMW read phase: bus goes idle at once, the write never happens.
        cmd_valid = 1'b1;
        cmd_op = 3'd2; cmd_addr = 3'd4; cmd_data = 32'hFFFF_FFFF; cmd_mask = 32'hFFFF_FFFF;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("rmw_rd_cs", 64'(avm_chipselect), 64'(1));
        chk("rmw_rd_wn", 64'(avm_write_n), 64'(1));
        reset_n = 1'b0;
        #1;
        chk_idle_bus("async_rst");
        chk("async_rst_valid", 64'(rsp_valid), 64'(0));
        chk("async_rst_ready", 64'(cmd_ready), 64'(1));
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("post_rst_valid", 64'(rsp_valid), 64'(0));
            chk_idle_bus("post_rst");
        end
        chk("no_abort_write", 64'(slv_mem[4]), 64'(ref_mem[4]));
        have_prev = 1'b0;

        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        run_cmd(3'd1, 3'd4, 32'h0, 32'h0, 0);

        for (int n = 0; n < 60; n++) begin
            logic [2:0] op;
            int stall;
            op = ($urandom_range(0, 9) > 7) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
            stall = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 5) : 0;
            run_cmd(op, AW'($urandom), $urandom, $urandom, stall);
        end
        for (int i = 0; i < NREG; i++) chk("final_mem", 64'(slv_mem[i]), 64'(ref_mem[i]));

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
